// File: rtl/serial_deser_buf_pkg.sv
// Shared types and helpers for the serial deserializer and its serializer peer.
// SERDES_PARITY_CHK_EN adds a trailing even-parity bit to every frame.
package serial_deser_buf_pkg;

    typedef enum logic {
        S_COLL  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    function automatic int cnt_width(input int w);
        return $clog2(w + 2);
    endfunction

    function automatic int frame_len(input int w);
`ifdef SERDES_PARITY_CHK_EN
        return w + 1;
`else
        return w;
`endif
    endfunction

endpackage

// File: rtl/serial_deser_buf_shift_in.sv
// Shift-in datapath: collects serial bits, counts them, latches frame order.
// Parity accumulation exists only when SERDES_PARITY_CHK_EN is defined.
module serial_shift_in
    import serial_deser_buf_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_acc,
    input  logic         i_sin,
    input  logic         i_msbf,
    input  logic         i_clr,
    output logic [W-1:0] o_sh,
    output logic [W-1:0] o_sh_next,
    output logic         o_last,
    output logic         o_par,
    output logic         o_par_next
);

    localparam int CW   = cnt_width(W);
    localparam int FLEN = frame_len(W);
    localparam logic [CW-1:0] LAST = CW'(FLEN - 1);
    localparam logic [CW-1:0] DLEN = CW'(W);

    logic [W-1:0]  r_sh;
    logic [CW-1:0] r_cnt;
    logic          r_mode;

    logic          w_first;
    logic          w_mode;
    logic [W-1:0]  w_shift;

    // The first bit of a frame already follows the freshly sampled order.
    assign w_first   = (r_cnt == '0);
    assign w_mode    = w_first ? i_msbf : r_mode;
    assign w_shift   = (w_mode == DIR_MSB_FIRST) ? {r_sh[W-2:0], i_sin}
                                                 : {i_sin, r_sh[W-1:1]};
    assign o_sh_next = (r_cnt < DLEN) ? w_shift : r_sh;
    assign o_sh      = r_sh;
    assign o_last    = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_mode <= DIR_LSB_FIRST;
        end else begin
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_acc) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (i_acc) begin
                r_sh <= o_sh_next;
                if (w_first) begin
                    r_mode <= i_msbf;
                end
            end
        end
    end

`ifdef SERDES_PARITY_CHK_EN
    logic r_par;

    // Running XOR over data and parity bit: nonzero means an odd total.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (i_acc) begin
            r_par <= w_first ? i_sin : (r_par ^ i_sin);
        end
    end

    assign o_par      = r_par;
    assign o_par_next = r_par ^ i_sin;
`else
    assign o_par      = 1'b0;
    assign o_par_next = 1'b0;
`endif

endmodule

// File: rtl/serial_deser_buf.sv
// Double-buffered serial-to-parallel receiver with valid/ready output.
// SERDES_PARITY_CHK_EN enables the trailing parity bit and PERR reporting.
module serial_deser_buf
    import serial_deser_buf_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RES,
    input  logic         SIN,
    input  logic         SVAL,
    output logic         SRDY,
    input  logic         MSBF,
    output logic [W-1:0] DOUT,
    output logic         OVAL,
    input  logic         ORDY,
    output logic         PERR
);

    state_t       r_state;
    logic [W-1:0] r_dout;
    logic         r_oval;
    logic         r_perr;

    logic [W-1:0] w_sh;
    logic [W-1:0] w_sh_next;
    logic         w_last;
    logic         w_par;
    logic         w_par_next;
    logic         w_acc;
    logic         w_done;
    logic         w_free;
    logic         w_drain;
    logic         w_clr;

    assign SRDY    = (r_state == S_COLL);
    assign w_acc   = SVAL && SRDY;
    assign w_done  = w_acc && w_last;
    assign w_drain = r_oval && ORDY;
    assign w_free  = !r_oval || ORDY;
    assign w_clr   = (r_state == S_COLL) ? (w_done && w_free) : w_drain;

    serial_shift_in #(.W(W)) u_shift (
        .clk        (CLK),
        .rst        (RES),
        .i_acc      (w_acc),
        .i_sin      (SIN),
        .i_msbf     (MSBF),
        .i_clr      (w_clr),
        .o_sh       (w_sh),
        .o_sh_next  (w_sh_next),
        .o_last     (w_last),
        .o_par      (w_par),
        .o_par_next (w_par_next)
    );

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state <= S_COLL;
            r_dout  <= '0;
            r_oval  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            unique case (r_state)
                S_COLL: begin
                    if (w_done && w_free) begin
                        r_dout <= w_sh_next;
                        r_oval <= 1'b1;
                        r_perr <= w_par_next;
                    end else begin
                        if (w_done) begin
                            r_state <= S_STALL;
                        end
                        if (w_drain) begin
                            r_oval <= 1'b0;
                            r_perr <= 1'b0;
                        end
                    end
                end
                // Held word moves out as soon as the consumer drains.
                S_STALL: begin
                    if (w_drain) begin
                        r_dout  <= w_sh;
                        r_perr  <= w_par;
                        r_state <= S_COLL;
                    end
                end
                default: r_state <= S_COLL;
            endcase
        end
    end

    assign DOUT = r_dout;
    assign OVAL = r_oval;
    assign PERR = r_perr;

endmodule

// File: tb/tb_serial_deser_buf.sv
// Scoreboard bench for serial_deser_buf: bit-stream model vs parallel output.
// Define SERDES_PARITY_CHK_EN to exercise the parity frame format.
module tb_serial_deser_buf;

    localparam int W = 4;
`ifdef SERDES_PARITY_CHK_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         CLK = 1'b0;
    logic         RES = 1'b1;
    logic         SIN = 1'b0;
    logic         SVAL = 1'b0;
    logic         SRDY;
    logic         MSBF = 1'b0;
    logic [W-1:0] DOUT;
    logic         OVAL;
    logic         ORDY = 1'b0;
    logic         PERR;

    always #5 CLK = ~CLK;

    serial_deser_buf #(.W(W)) dut (
        .CLK  (CLK),
        .RES  (RES),
        .SIN  (SIN),
        .SVAL (SVAL),
        .SRDY (SRDY),
        .MSBF (MSBF),
        .DOUT (DOUT),
        .OVAL (OVAL),
        .ORDY (ORDY),
        .PERR (PERR)
    );

    int   n_chk = 0;
    int   n_err = 0;
    logic g_res = 1'b1;
    logic g_msbf = 1'b0;
    logic g_ordy = 1'b1;
    logic g_rand = 1'b0;

    logic [W:0] sb_q[$];
    logic       m_bits[$];
    logic       m_mode;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: order fixed by the first bit, word built arithmetically.
    function automatic void model_bit(input logic b);
        logic [W-1:0] word;
        logic         perr;
        if (m_bits.size() == 0) m_mode = MSBF;
        m_bits.push_back(b);
        if (m_bits.size() == FLEN) begin
            word = '0;
            for (int i = 0; i < W; i++) begin
                if (m_mode) word = W'((word * 2) + W'(m_bits[i]));
                else        word[i] = m_bits[i];
            end
            perr = 1'b0;
`ifdef SERDES_PARITY_CHK_EN
            perr = (^word) ^ m_bits[W];
`endif
            sb_q.push_back({perr, word});
            m_bits.delete();
        end
    endfunction

    task automatic drive(input logic sv, input logic b, output logic acc);
        @(posedge CLK);
        #1;
        RES  = g_res;
        SVAL = sv;
        SIN  = b;
        MSBF = g_msbf;
        ORDY = g_rand ? 1'($urandom_range(0, 1)) : g_ordy;
        @(negedge CLK);
        acc = SVAL && SRDY && !RES;
        if (acc) model_bit(SIN);
    endtask

    task automatic idle();
        logic a;
        drive(1'b0, 1'b0, a);
    endtask

    task automatic send_bit(input logic b);
        logic a;
        for (int t = 0; t < 200; t++) begin
            drive(1'b1, b, a);
            if (a) return;
        end
        check("send_bit_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [W-1:0] word, input logic msbf,
                             input int gap, input int tog_at, input logic pflip);
        int idx;
        g_msbf = msbf;
        for (int i = 0; i < W; i++) begin
            idx = msbf ? (W - 1 - i) : i;
            if (i == tog_at) g_msbf = ~msbf;
            send_bit(word[idx]);
            if (i < W - 1) repeat (gap) idle();
        end
`ifdef SERDES_PARITY_CHK_EN
        send_bit((^word) ^ pflip);
`else
        if (pflip) g_msbf = msbf;
`endif
    endtask

    task automatic do_reset();
        g_res = 1'b1;
        idle();
        m_bits.delete();
        sb_q.delete();
        idle();
        g_res = 1'b0;
    endtask

    logic         p_hold = 1'b0;
    logic [W-1:0] p_dout = '0;

    initial begin : monitor
        logic [W:0] e;
        forever begin
            @(negedge CLK);
            if (!RES) begin
                if (p_hold) begin
                    check("hold_oval", 32'(OVAL), 32'd1);
                    check("hold_dout", 32'(DOUT), 32'(p_dout));
                end
                if (OVAL && ORDY) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_word", 32'(DOUT), 32'hFFFF_FFFF);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_dout", 32'(DOUT), 32'(e[W-1:0]));
                        check("sb_perr", 32'(PERR), 32'(e[W]));
                    end
                end
                p_hold = OVAL && !ORDY;
                p_dout = DOUT;
            end else begin
                p_hold = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    initial begin : stim
        do_reset();
        idle();
        check("rst_dout", 32'(DOUT), 32'd0);
        check("rst_oval", 32'(OVAL), 32'd0);
        check("rst_srdy", 32'(SRDY), 32'd1);
        check("rst_perr", 32'(PERR), 32'd0);

        g_ordy = 1'b1;
        send_word(4'b1011, 1'b1, 0, -1, 1'b0);
        idle();
        check("msb_oval", 32'(OVAL), 32'd1);
        check("msb_dout", 32'(DOUT), 32'hB);
        idle();
        check("msb_oval_1cyc", 32'(OVAL), 32'd0);

        send_word(4'b1101, 1'b0, 1, -1, 1'b0);
        idle();
        check("lsb_dout", 32'(DOUT), 32'hD);
        check("lsb_oval", 32'(OVAL), 32'd1);
        send_word(4'b1101, 1'b0, 1, 2, 1'b0);
        idle();
        check("lsb_tog_dout", 32'(DOUT), 32'hD);

        g_ordy = 1'b0;
        send_word(4'hA, 1'b1, 0, -1, 1'b0);
        send_word(4'h5, 1'b1, 0, -1, 1'b0);
        idle();
        check("bp_srdy", 32'(SRDY), 32'd0);
        check("bp_dout", 32'(DOUT), 32'hA);
        check("bp_oval", 32'(OVAL), 32'd1);
        g_ordy = 1'b1;
        idle();
        g_ordy = 1'b0;
        idle();
        check("bp2_dout", 32'(DOUT), 32'h5);
        check("bp2_oval", 32'(OVAL), 32'd1);
        check("bp2_srdy", 32'(SRDY), 32'd1);
        g_ordy = 1'b1;
        idle();
        idle();
        check("bp_drained", 32'(OVAL), 32'd0);

        g_msbf = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        do_reset();
        send_word(4'h3, 1'b1, 0, -1, 1'b0);
        idle();
        check("midrst_dout", 32'(DOUT), 32'h3);
        check("midrst_oval", 32'(OVAL), 32'd1);

`ifdef SERDES_PARITY_CHK_EN
        send_word(4'b1011, 1'b1, 0, -1, 1'b0);
        idle();
        check("par_ok_perr", 32'(PERR), 32'd0);
        send_word(4'b1011, 1'b1, 0, -1, 1'b1);
        idle();
        check("par_bad_perr", 32'(PERR), 32'd1);
        check("par_bad_dout", 32'(DOUT), 32'hB);
`endif

        g_rand = 1'b1;
        for (int n = 0; n < 60 * FLEN; n++) begin
            if ($urandom_range(0, 3) == 0) g_msbf = 1'($urandom_range(0, 1));
            send_bit(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) idle();
        end
        g_rand = 1'b0;
        g_ordy = 1'b1;
        for (int t = 0; t < 50; t++) begin
            if (sb_q.size() == 0 && !OVAL) break;
            idle();
        end
        check("final_queue_empty", 32'(sb_q.size()), 32'd0);
        check("final_oval", 32'(OVAL), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
